// File: rtl/row_reverse_stream.sv
// Horizontal-flip engine: ping-pong two row banks, emit each row last column first.
// Latency: first pixel of a row is valid 3 cycles after that row's last input handshake.
// Backpressure: reads stop when output register + skid are committed; input stalls when both banks are occupied.
module row_reverse_stream #(
  parameter int MAX_WIDTH = 4096,
  parameter int ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   cfg_width,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [23:0]       s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [23:0]       m_data,
  output logic              m_last,
  output logic              busy,
  output logic [15:0]       rows_out
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

  localparam logic [ADDR_W:0] MAX_W = (ADDR_W+1)'(MAX_WIDTH);

  bank_st_t          st_q [0:1];
  bank_st_t          st_d [0:1];
  logic [ADDR_W:0]   w;
  logic [ADDR_W:0]   w_m1;
  logic [ADDR_W:0]   cfg_clamped;
  logic              wr_sel, rd_sel;
  logic [ADDR_W-1:0] wa, ra, rd_addr;
  logic [23:0]       mem [0:2*MAX_WIDTH-1];
  logic [23:0]       ram_q;
  logic              rd_pend, rd_pend_last;
  logic              sk_valid, sk_last;
  logic [23:0]       sk_data;
  logic              wr_fire, wr_last, wr_bank_open;
  logic              rd_active, rd_space, rd_fire, rd_done;
  logic              keep, out_free;

  // Handshake and pointer decode shared by both banks and the output stage.
  always_comb begin
    w_m1         = w - 1'b1;
    cfg_clamped  = (cfg_width > MAX_W) ? MAX_W : cfg_width;
    rd_active    = (st_q[rd_sel] == FULL) || (st_q[rd_sel] == DRAINING);
    // A FULL bank issues its first read (column w-1) in the same cycle it starts draining.
    rd_addr      = (st_q[rd_sel] == FULL) ? w_m1[ADDR_W-1:0] : ra;
    keep         = m_valid && !m_ready;
    out_free     = !m_valid || m_ready;
    // At most one of {held output, skid, in-flight read} may be occupied before issuing another read.
    rd_space     = !((keep && sk_valid) || (keep && rd_pend) || (sk_valid && rd_pend));
    rd_fire      = rd_active && rd_space;
    rd_done      = rd_fire && (rd_addr == '0);
    // A bank finishing its drain this cycle is writable in the same cycle.
    wr_bank_open = (st_q[wr_sel] == EMPTY) || (st_q[wr_sel] == FILLING) ||
                   (rd_done && (rd_sel == wr_sel));
    s_ready      = (w != '0) && wr_bank_open;
    wr_fire      = s_valid && s_ready;
    wr_last      = ({1'b0, wa} == w_m1);
    busy         = (st_q[0] != EMPTY) || (st_q[1] != EMPTY) || m_valid || sk_valid || rd_pend;
  end

  // Bank next-state: drain update first, write update last so a same-cycle refill wins.
  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    if (rd_fire) st_d[rd_sel] = rd_done ? EMPTY : DRAINING;
    if (wr_fire) st_d[wr_sel] = wr_last ? FULL : FILLING;
  end

  // Bank state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
    end
  end

  // Width latch, bank selects and write/read pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w      <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wa     <= '0;
      ra     <= '0;
    end else begin
      if (!busy && !wr_fire) w <= cfg_clamped;
      if (wr_fire) begin
        if (wr_last) begin
          wa     <= '0;
          wr_sel <= ~wr_sel;
        end else begin
          wa <= wa + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_done) rd_sel <= ~rd_sel;
        else         ra     <= rd_addr - 1'b1;
      end
    end
  end

  // Row storage; read returns the old word when the same address is rewritten in that cycle.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_sel, wa}] <= s_data;
    if (rd_fire) ram_q <= mem[{rd_sel, rd_addr}];
  end

  // Output register with one-entry skid catching the read already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      sk_valid     <= 1'b0;
      sk_data      <= '0;
      sk_last      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      rows_out     <= '0;
    end else begin
      rd_pend      <= rd_fire;
      rd_pend_last <= rd_done;
      if (out_free) begin
        if (sk_valid) begin
          m_valid <= 1'b1;
          m_data  <= sk_data;
          m_last  <= sk_last;
        end else if (rd_pend) begin
          m_valid <= 1'b1;
          m_data  <= ram_q;
          m_last  <= rd_pend_last;
        end else begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      end
      if (out_free && sk_valid)      sk_valid <= rd_pend;
      else if (!out_free && rd_pend) sk_valid <= 1'b1;
      if (rd_pend && (sk_valid || !out_free)) begin
        sk_data <= ram_q;
        sk_last <= rd_pend_last;
      end
      if (m_valid && m_ready && m_last) rows_out <= rows_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_row_reverse_stream.sv
// Directed bench for row_reverse_stream: reversal, latency, backpressure, boundaries, reset.
// Expected streams are built from the source rows by reversing each row in the bench.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_row_reverse_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] cfg_width;
  logic        s_valid, s_ready;
  logic [23:0] s_data;
  logic        m_valid, m_ready, m_last, busy;
  logic [23:0] m_data;
  logic [15:0] rows_out;

  row_reverse_stream #(.MAX_WIDTH(4096), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .rows_out(rows_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int first_in_hs, last_in_hs, first_out_hs, last_out_hs, first_v;
  int sent;

  logic [23:0] src   [$];
  logic [23:0] exp_q [$];
  logic        exp_last [$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    first_in_hs = -1; last_in_hs = -1; first_out_hs = -1; last_out_hs = -1; first_v = -1;
  endtask

  // Queue rows of source pixels and the reversed expected output.
  task automatic add_rows(input int w, input int rows, input bit rnd, input logic [23:0] base);
    logic [23:0] row [$];
    for (int r = 0; r < rows; r++) begin
      row.delete();
      for (int c = 0; c < w; c++) begin
        logic [23:0] v;
        v = rnd ? 24'($urandom) : base + 24'(r * w + c);
        row.push_back(v);
        src.push_back(v);
      end
      for (int c = w - 1; c >= 0; c--) begin
        exp_q.push_back(row[c]);
        exp_last.push_back(c == 0);
      end
    end
  endtask

  task automatic produce(input int budget, output int n_sent);
    int cyc = 0;
    n_sent = 0;
    while (src.size() > 0 && cyc < budget) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = src[0];
      @(negedge clk);
      if (s_ready) begin
        src.delete(0);
        n_sent++;
        if (first_in_hs < 0) first_in_hs = cyc_cnt;
        last_in_hs = cyc_cnt;
      end
      cyc++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic consume(input bit rnd, input int budget);
    int cyc = 0;
    bit held_vld = 1'b0;
    logic [23:0] held_data;
    logic held_last;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(posedge clk); #1;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (held_vld) begin
        chk("stable_vld", m_valid, 1);
        chk("stable_data", m_data, held_data);
        chk("stable_last", m_last, held_last);
      end
      held_vld  = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
      if (m_valid && first_v < 0) first_v = cyc_cnt;
      if (m_valid && m_ready) begin
        chk("data", m_data, exp_q.pop_front());
        chk("last", m_last, exp_last.pop_front());
        if (first_out_hs < 0) first_out_hs = cyc_cnt;
        last_out_hs = cyc_cnt;
      end
      cyc++;
    end
    chk("out_remaining", exp_q.size(), 0);
  endtask

  task automatic run_rows(input bit rnd, input int budget);
    int n;
    fork
      produce(budget, n);
      consume(rnd, budget);
    join
    chk("in_remaining", src.size(), 0);
  endtask

  task automatic do_reset(input logic [12:0] cfg);
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; cfg_width = cfg;
    src.delete(); exp_q.delete(); exp_last.delete();
    clear_stats();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cfg_width = 13'd4; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    clear_stats();

    // Reset state, then width latch one cycle after release and s_ready the cycle after.
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rows_out", rows_out, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rdy_first_cycle", s_ready, 0);
    @(negedge clk);
    chk("rdy_second_cycle", s_ready, 1);

    // Single row w=4 and its latency.
    add_rows(4, 1, 1'b0, 24'h000001);
    run_rows(1'b0, 100);
    chk("single_latency", first_v - last_in_hs, 3);
    repeat (2) @(negedge clk);
    chk("single_rows_out", rows_out, 1);
    chk("single_idle", busy, 0);

    // Back-to-back rows w=8, continuous on both sides.
    do_reset(13'd8);
    add_rows(8, 4, 1'b0, 24'h000001);
    run_rows(1'b0, 200);
    chk("b2b_in_span", last_in_hs - first_in_hs, 31);
    chk("b2b_out_span", last_out_hs - first_out_hs, 31);
    repeat (2) @(negedge clk);
    chk("b2b_rows_out", rows_out, 4);
    chk("b2b_idle", busy, 0);

    // Backpressure w=3: six accepted, then stall until bank 0 drains.
    do_reset(13'd3);
    add_rows(3, 3, 1'b0, 24'h000001);
    m_ready = 1'b0;
    produce(20, sent);
    chk("bp_accepted", sent, 6);
    @(negedge clk);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_hold_valid", m_valid, 1);
    chk("bp_hold_data", m_data, 24'h000003);
    run_rows(1'b0, 100);
    repeat (2) @(negedge clk);
    chk("bp_rows_out", rows_out, 3);

    // Random backpressure, w=5, 10 rows of random pixels.
    do_reset(13'd5);
    add_rows(5, 10, 1'b1, 24'h0);
    run_rows(1'b1, 1000);
    repeat (4) begin @(posedge clk); #1 m_ready = 1'b1; end
    @(negedge clk);
    chk("rnd_rows_out", rows_out, 10);

    // w=1: every pixel passes unchanged with m_last set.
    do_reset(13'd1);
    add_rows(1, 6, 1'b0, 24'hABC000);
    run_rows(1'b0, 100);
    repeat (2) @(negedge clk);
    chk("w1_rows_out", rows_out, 6);

    // cfg_width above maximum clamps to 4096.
    do_reset(13'd5000);
    add_rows(4096, 1, 1'b0, 24'h100000);
    run_rows(1'b0, 20000);
    repeat (2) @(negedge clk);
    chk("clamp_rows_out", rows_out, 1);
    chk("clamp_idle", busy, 0);

    // cfg_width=0 never accepts.
    do_reset(13'd0);
    src.push_back(24'h123456);
    produce(10, sent);
    chk("w0_accepted", sent, 0);
    @(negedge clk);
    chk("w0_s_ready", s_ready, 0);

    // Reset after 2 of 4 pixels, then a clean row.
    do_reset(13'd4);
    add_rows(4, 1, 1'b0, 24'h000001);
    produce(2, sent);
    chk("mid_accepted", sent, 2);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    do_reset(13'd4);
    add_rows(4, 1, 1'b0, 24'h000011);
    run_rows(1'b0, 100);
    repeat (2) @(negedge clk);
    chk("mid_rows_out", rows_out, 1);

    // cfg_width change while busy waits until idle.
    do_reset(13'd4);
    add_rows(4, 1, 1'b0, 24'h000001);
    produce(2, sent);
    chk("cfg_busy", busy, 1);
    cfg_width = 13'd2;
    run_rows(1'b0, 100);
    repeat (3) @(negedge clk);
    add_rows(2, 1, 1'b0, 24'h000005);
    run_rows(1'b0, 100);
    repeat (2) @(negedge clk);
    chk("cfg_rows_out", rows_out, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
